// File: rtl/fila_pkg.sv
// Shared definitions for the FILA queue and its reader.
package fila_pkg;

   localparam int QUEUE_DEPTH = 8;
   localparam int DATA_W      = 8;
   localparam int LEN_W       = 4;
   localparam int CNT_W       = 3;

   typedef enum logic [2:0] {
      IDLE,
      REQUEST,
      WAIT_DATA,
      SHIFT,
      GAP
   } reader_state_t;

endpackage

// File: rtl/fila_shift_tx.sv
// 8-bit parallel-in serial-out shifter, MSB first, with a bit counter.
module fila_shift_tx
   import fila_pkg::*;
(
   input  logic              clock_10KHz,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] data,
   output logic              msb,
   output logic              last_bit
);

   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;

   // Load a fresh byte, or move the next bit into the MSB position.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_10KHz or negedge reset) begin
      if (!reset) begin
         // NOTE: the data register is cleared too, so a discarded byte never resurfaces.
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= data;
         bit_cnt <= CNT_W'(DATA_W - 1);
      end else if (shift) begin
         shreg   <= {shreg[DATA_W-2:0], 1'b0};
         bit_cnt <= bit_cnt - 1'b1;
      end
   end

   assign msb      = shreg[DATA_W-1];
   assign last_bit = (bit_cnt == '0);

endmodule

// File: rtl/fila_reader.sv
// Consumer end of the FILA queue: pops a byte, waits for it to settle,
// then streams it MSB-first over a per-bit valid/ready link.
module fila_reader
   import fila_pkg::*;
#(
   parameter int DEQ_LATENCY = 3,
   parameter int GAP_CYCLES  = 2
) (
   input  logic              clock_10KHz,
   input  logic              reset,
   input  logic              enable_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              dequeue_out,
   output logic              ser_data_out,
   output logic              ser_valid_out,
   input  logic              ser_ready_in,
   output logic              busy_out,
   output logic [7:0]        byte_count_out
);

   reader_state_t    state, state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] gap_cnt;
   logic [7:0]       byte_count;
   logic             dequeue_q;
   logic             load_byte;
   logic             shift_bit;
   logic             byte_done;
   logic             tx_msb;
   logic             tx_last_bit;

   fila_shift_tx u_shift_tx (
      .clock_10KHz (clock_10KHz),
      .reset       (reset),
      .load        (load_byte),
      .shift       (shift_bit),
      .data        (data_in),
      .msb         (tx_msb),
      .last_bit    (tx_last_bit)
   );

   // Next-state decode and the one-cycle strobes that steer the datapath.
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      state_next = state;
      load_byte  = 1'b0;
      shift_bit  = 1'b0;
      byte_done  = 1'b0;
      case (state)
         IDLE:      if (enable_in && len_in != '0) state_next = REQUEST;
         REQUEST:   state_next = WAIT_DATA;
         WAIT_DATA: begin
            // The count reaches zero on this edge: the popped byte has settled.
            if (wait_cnt <= CNT_W'(1)) begin
               load_byte  = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready_in) begin
               shift_bit = 1'b1;
               if (tx_last_bit) begin
                  byte_done  = 1'b1;
                  state_next = GAP;
               end
            end
         end
         GAP:       if (gap_cnt == '0) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // State register, settle/gap counters, byte counter and the pop pulse.
   always_ff @(posedge clock_10KHz or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         gap_cnt    <= '0;
         byte_count <= '0;
         dequeue_q  <= 1'b0;
      end else begin
         state     <= state_next;
         // Registered so the pop is a clean single pulse aligned with REQUEST.
         dequeue_q <= (state_next == REQUEST);

         if (state == REQUEST) begin
            wait_cnt <= CNT_W'(DEQ_LATENCY - 1);
         end else if (state == WAIT_DATA && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end

         if (byte_done) begin
            gap_cnt    <= CNT_W'(GAP_CYCLES - 1);
            byte_count <= byte_count + 1'b1;
         end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   assign dequeue_out    = dequeue_q;
   assign ser_valid_out  = (state == SHIFT);
   assign ser_data_out   = (state == SHIFT) && tx_msb;
   assign busy_out       = (state != IDLE);
   assign byte_count_out = byte_count;

endmodule
